// File: rtl/nco_pkg.sv
// Shared widths, sweep state encoding and quarter-wave table generator
// for the I/Q numerically controlled oscillator.
package nco_pkg;

    localparam int PHASE_W_DEF   = 32;
    localparam int OUTPUT_W_DEF  = 12;
    localparam int LUT_ADDR_DEF  = 10;
    localparam int LATENCY       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } sweep_state_t;

    // Half-sample offset lets the mirrored quadrants reuse the same entries.
    function automatic int qw_entry(int k, int law, int ow);
        real amp;
        real ang;
        amp = real'((1 << (ow - 1)) - 1);
        ang = 2.0 * 3.14159265358979 * (real'(k) + 0.5) / real'(1 << law);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/nco_qw_rom.sv
// Dual-read synchronous quarter-wave sine table with registered outputs.
// Contents are elaborated from the package generator.
module nco_qw_rom
    import nco_pkg::*;
#(
    parameter int LUT_ADDR_WIDTH = LUT_ADDR_DEF,
    parameter int OUTPUT_WIDTH   = OUTPUT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [LUT_ADDR_WIDTH-3:0] sin_idx,
    input  logic [LUT_ADDR_WIDTH-3:0] cos_idx,
    output logic [OUTPUT_WIDTH-1:0]   sin_val,
    output logic [OUTPUT_WIDTH-1:0]   cos_val
);

    localparam int DEPTH = 1 << (LUT_ADDR_WIDTH - 2);

    logic [OUTPUT_WIDTH-1:0] tab [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tab
        assign tab[k] = OUTPUT_WIDTH'(qw_entry(k, LUT_ADDR_WIDTH, OUTPUT_WIDTH));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sin_val <= '0;
            cos_val <= '0;
        end else begin
            sin_val <= tab[sin_idx];
            cos_val <= tab[cos_idx];
        end
    end

endmodule

// File: rtl/nco_qw_iq.sv
// Phase accumulator with offset, linear sweep and a four-stage
// quarter-wave sine/cosine pipeline.
module nco_qw_iq
    import nco_pkg::*;
#(
    parameter int PHASE_WIDTH    = PHASE_W_DEF,
    parameter int OUTPUT_WIDTH   = OUTPUT_W_DEF,
    parameter int LUT_ADDR_WIDTH = LUT_ADDR_DEF
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic                    cfg_load_i,
    input  logic [PHASE_WIDTH-1:0]  phi_inc_i,
    input  logic [PHASE_WIDTH-1:0]  phi_ofs_i,
    input  logic                    phase_clr_i,
    input  logic                    sweep_start_i,
    input  logic [PHASE_WIDTH-1:0]  sweep_step_i,
    input  logic [PHASE_WIDTH-1:0]  sweep_stop_i,
    output logic                    sweep_done_o,
    output logic [OUTPUT_WIDTH-1:0] sin_out,
    output logic [OUTPUT_WIDTH-1:0] cos_out,
    output logic                    out_valid
);

    localparam int PW  = PHASE_WIDTH;
    localparam int LAW = LUT_ADDR_WIDTH;
    localparam int OW  = OUTPUT_WIDTH;
    localparam int QTR = 1 << (LAW - 2);

    logic [PW-1:0]    acc;
    logic [PW-1:0]    inc_reg;
    logic [PW-1:0]    ofs_reg;
    logic [PW-1:0]    inc_d;
    logic [PW:0]      sum;
    logic             done_d;
    sweep_state_t     state_q;
    sweep_state_t     state_d;

    assign sum = {1'b0, inc_reg} + {1'b0, sweep_step_i};

    always_comb begin
        state_d = state_q;
        inc_d   = inc_reg;
        done_d  = 1'b0;
        if (cfg_load_i) begin
            inc_d   = phi_inc_i;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (sweep_start_i) state_d = SWEEP;
                SWEEP: begin
                    if (en) begin
                        if (sum >= {1'b0, sweep_stop_i}) begin
                            inc_d   = sweep_stop_i;
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end else begin
                            inc_d = sum[PW-1:0];
                        end
                    end
                end
                HOLD: if (sweep_start_i) state_d = SWEEP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            inc_reg      <= '0;
            ofs_reg      <= '0;
            sweep_done_o <= 1'b0;
            acc          <= '0;
        end else begin
            state_q      <= state_d;
            inc_reg      <= inc_d;
            sweep_done_o <= done_d;
            if (cfg_load_i) ofs_reg <= phi_ofs_i;
            if (phase_clr_i) acc <= '0;
            else if (en) acc <= acc + inc_reg;
        end
    end

    logic [PW-1:0]    p;
    logic [LAW-1:0]   addr;
    logic [LAW-1:0]   s1_addr;
    logic [LAW-1:0]   s1_caddr;
    logic [LAW-3:0]   s2_sidx;
    logic [LAW-3:0]   s2_cidx;
    logic             s2_sneg;
    logic             s2_cneg;
    logic             s3_sneg;
    logic             s3_cneg;
    logic [OW-1:0]    rom_sin;
    logic [OW-1:0]    rom_cos;
    logic [LATENCY:0] vpipe;

    // Round the truncated phase half-up; the sum wraps naturally.
    assign p    = acc + ofs_reg;
    assign addr = p[PW-1 -: LAW] + LAW'(p[PW-LAW-1]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_addr  <= '0;
            s1_caddr <= '0;
            s2_sidx  <= '0;
            s2_cidx  <= '0;
            s2_sneg  <= 1'b0;
            s2_cneg  <= 1'b0;
            s3_sneg  <= 1'b0;
            s3_cneg  <= 1'b0;
            sin_out  <= '0;
            cos_out  <= '0;
            vpipe    <= '0;
        end else begin
            s1_addr  <= addr;
            s1_caddr <= addr + LAW'(QTR);
            s2_sidx  <= s1_addr[LAW-2] ? ~s1_addr[LAW-3:0] : s1_addr[LAW-3:0];
            s2_cidx  <= s1_caddr[LAW-2] ? ~s1_caddr[LAW-3:0] : s1_caddr[LAW-3:0];
            s2_sneg  <= s1_addr[LAW-1];
            s2_cneg  <= s1_caddr[LAW-1];
            s3_sneg  <= s2_sneg;
            s3_cneg  <= s2_cneg;
            sin_out  <= s3_sneg ? -rom_sin : rom_sin;
            cos_out  <= s3_cneg ? -rom_cos : rom_cos;
            vpipe    <= {vpipe[LATENCY-1:0], en};
        end
    end

    assign out_valid = vpipe[LATENCY];

    nco_qw_rom #(
        .LUT_ADDR_WIDTH(LAW),
        .OUTPUT_WIDTH  (OW)
    ) u_rom (
        .clk    (clk),
        .reset_n(reset_n),
        .sin_idx(s2_sidx),
        .cos_idx(s2_cidx),
        .sin_val(rom_sin),
        .cos_val(rom_cos)
    );

endmodule

// File: doc/nco_qw_iq.md
Name: nco_qw_iq

Overview:
- Parametrised successor to the single-output ROM NCO: phase accumulator feeding quarter-wave LUT sine/cosine synthesis.
- Adds: programmable phase offset, synchronous phase clear, linear frequency-sweep FSM, enable gating, and an out_valid aligned with pipeline latency.
- Sits between the control registers and the DSP chain; it is the I/Q source for mixers and filter test stimulus.

Parameters:
- PHASE_WIDTH, 32, accumulator/increment/offset width.
- OUTPUT_WIDTH, 12, signed two's-complement sample width.
- LUT_ADDR_WIDTH, 10, full-cycle phase resolution; the quarter table holds 2^(LUT_ADDR_WIDTH-2) entries.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  advance accumulator this cycle; also feeds the valid pipe.
- cfg_load_i  in  1  pulse: latch phi_inc_i into inc_reg and phi_ofs_i into ofs_reg; abort any sweep.
- phi_inc_i  in  PHASE_WIDTH  frequency word.
- phi_ofs_i  in  PHASE_WIDTH  phase offset.
- phase_clr_i  in  1  synchronous accumulator clear.
- sweep_start_i  in  1  pulse: start linear sweep from the current inc_reg.
- sweep_step_i  in  PHASE_WIDTH  per-en increment of inc_reg.
- sweep_stop_i  in  PHASE_WIDTH  sweep end frequency, unsigned.
- sweep_done_o  out  1  one-cycle pulse when the stop frequency is reached.
- sin_out  out  OUTPUT_WIDTH  signed sine.
- cos_out  out  OUTPUT_WIDTH  signed cosine.
- out_valid  out  1  sin_out/cos_out are valid.

Behaviour:
- Reset: acc, inc_reg, ofs_reg, all pipe registers, sin_out, cos_out, out_valid and sweep_done_o are 0; FSM is IDLE. Reset mid-run clears immediately, with no flush.
- Accumulator precedence per cycle:
  - phase_clr_i: acc<=0, even if en=1.
  - else en: acc<=acc+inc_reg, wrapping mod 2^PHASE_WIDTH.
  - else hold.
- cfg_load_i: new inc takes effect from the next en cycle. It has priority over sweep updates in the same cycle.
- Sweep FSM, states IDLE, SWEEP, HOLD:
  - IDLE -> SWEEP on sweep_start_i.
  - In SWEEP, on each en: if inc_reg+sweep_step_i >= sweep_stop_i (unsigned, computed one bit wider) then inc_reg<=sweep_stop_i, go to HOLD, and pulse sweep_done_o for 1 cycle. Otherwise inc_reg<=inc_reg+sweep_step_i.
  - HOLD: inc_reg frozen. sweep_start_i restarts into SWEEP; cfg_load_i -> IDLE.
  - cfg_load_i in SWEEP -> IDLE with no done pulse.
  - sweep_start_i while in SWEEP is ignored.
- Stage 1 (registered):
  - p = acc + ofs_reg.
  - addr = p[PW-1:PW-LAW] + p[PW-LAW-1] (round-half-up), wrapping mod 2^LAW.
  - caddr = addr + 2^(LAW-2).
- Stage 2 (registered quadrant decode, per path): q = top 2 bits, idx = low LAW-2 bits.
  - ROM index = idx for q0/q2, ~idx for q1/q3.
  - neg flag = q[1].
- Stage 3: dual-read ROM, registered output.
- Stage 4: output register = neg ? -T : T.
- Table contents: T[k] = round((2^(OW-1)-1)*sin(2π(k+0.5)/2^LAW)), a half-sample offset so mirroring needs no extra entry. Values are positive, and negation never overflows.
- Latency:
  - The sample for the acc value written at edge t appears at edge t+4.
  - out_valid = en delayed 5 clocks (4-stage pipe plus accumulator update), tracking that sample exactly.
  - When en is low, the pipe still runs but out_valid is 0 for those slots.

Decomposition:
- Package nco_pkg holds:
  - default widths;
  - the sweep state enum (IDLE/SWEEP/HOLD);
  - the LATENCY=4 constant;
  - a function generating T[] for ROM init.
- One sub-module: nco_qw_rom, a dual-port synchronous quarter-wave ROM parametrised by LUT_ADDR_WIDTH/OUTPUT_WIDTH and initialised from the package function.

Test Plan:
All scenarios use defaults: PW=32, LAW=10, OW=12, T[0]=6, T[255]=2047.
- Reset: drive en/inc mid-run, assert reset_n=0 -> all outputs 0 asynchronously; after release, out_valid stays 0 for 5 cycles after the first en.
- Quarter-step: load inc=0x40000000, ofs=0, clear, en=1 -> sin 6, 2047, -6, -2047 repeating; cos 2047, -6, -2047, 6; first valid 5 cycles after en.
- Offset: inc=0, ofs=0x40000000 -> sin constant 2047, cos constant -6 once valid.
- Rounding wrap: inc=0xFFE00000, single en pulse -> acc=0xFFE00000, addr rounds 1023+1 -> 0, so sin=6 and cos=2047.
- Sweep:
  - Set inc=0x100, step=0x100, stop=0x400, pulse start with en=1 -> inc_reg 0x200, 0x300, 0x400, then HOLD.
  - sweep_done_o high exactly one cycle, coincident with the 0x400 load; inc_reg stays 0x400 afterwards.
- Abort/priority:
  - cfg_load_i in SWEEP -> IDLE, no done pulse, inc_reg=phi_inc_i.
  - phase_clr_i with en=1 -> acc=0 next cycle.
